// File: rtl/uart_arbiter.sv
// uart_arbiter: round-robin TX arbiter and RX poller that owns every UART register cycle; grant timeout enabled by UART_ARB_TIMEOUT_EN
module uart_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TMO_SZ = 12
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_a_valid,
  input  logic [7:0] i_a_data,
  input  logic       i_a_last,
  output logic       o_a_ready,
  input  logic       i_b_valid,
  input  logic [7:0] i_b_data,
  input  logic       i_b_last,
  output logic       o_b_ready,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  input  logic       i_rx_ready,
  output logic       o_en,
  output logic       o_wr,
  output logic [3:0] o_addr,
  output logic [7:0] o_data,
  input  logic [7:0] i_data
);
  typedef enum logic [2:0] {IDLE, TXQ, TXW, TXD, RXQ, RXW, RXR, RXC} state_t;
  state_t state;
  logic gnt, gnt_b, rr_b, rx_turn, tx_pend, tx_last;
  logic [7:0] tx_byte;
  logic pick_b, can_fetch, rx_first, fetch;
  always_comb begin
    pick_b = gnt ? gnt_b : (i_a_valid && i_b_valid) ? rr_b : i_b_valid;
    can_fetch = pick_b ? i_b_valid : i_a_valid;
    rx_first = rx_turn && !o_rx_valid;
    fetch = !i_rst && state == IDLE && !rx_first && !tx_pend && can_fetch;
    o_en = state inside {TXQ, TXD, RXQ, RXR};
    o_wr = state == TXD;
    o_addr = state == TXD ? 4'd1 : state == RXQ ? 4'd2 : state == RXR ? 4'd3 : 4'd0;
    o_data = state == TXD ? tx_byte : 8'd0;
  end
  assign o_a_ready = fetch && !pick_b;
  assign o_b_ready = fetch && pick_b;
`ifdef UART_ARB_TIMEOUT_EN
  logic [TMO_SZ-1:0] tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo = ^{TIMEOUT_CYCLES[0], TMO_SZ[0]};
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      gnt <= 1'b0;
      gnt_b <= 1'b0;
      rr_b <= 1'b0;
      rx_turn <= 1'b0;
      tx_pend <= 1'b0;
      tx_last <= 1'b0;
      tx_byte <= 8'd0;
      o_rx_valid <= 1'b0;
      o_rx_data <= 8'd0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      if (o_rx_valid && i_rx_ready) o_rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_first) state <= RXQ;
          else if (tx_pend) state <= TXQ;
          else if (fetch) begin
            tx_byte <= pick_b ? i_b_data : i_a_data;
            tx_last <= pick_b ? i_b_last : i_a_last;
            tx_pend <= 1'b1;
            gnt <= 1'b1;
            gnt_b <= pick_b;
            state <= TXQ;
          end else if (!o_rx_valid) state <= RXQ;
        end
        TXQ: state <= TXW;
        TXW: begin
          state <= (i_data != 8'd0) ? TXD : IDLE;
          if (i_data == 8'd0) rx_turn <= 1'b1;
        end
        TXD: begin
          state <= IDLE;
          tx_pend <= 1'b0;
          rx_turn <= 1'b1;
          if (tx_last) begin
            gnt <= 1'b0;
            rr_b <= !gnt_b;
          end
        end
        RXQ: state <= RXW;
        RXW: begin
          state <= (i_data != 8'd0) ? RXR : IDLE;
          if (i_data == 8'd0) rx_turn <= 1'b0;
        end
        RXR: state <= RXC;
        RXC: begin
          o_rx_data <= i_data;
          o_rx_valid <= 1'b1;
          rx_turn <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef UART_ARB_TIMEOUT_EN
      // an idle granted client forfeits its grant after TIMEOUT_CYCLES idle-state cycles
      if (fetch) tmo_cnt <= '0;
      else if (gnt && !tx_pend && state == IDLE && !(gnt_b ? i_b_valid : i_a_valid)) begin
        if (tmo_cnt == TMO_SZ'(TIMEOUT_CYCLES - 1)) begin
          tmo_cnt <= '0;
          gnt <= 1'b0;
          rr_b <= !gnt_b;
        end else tmo_cnt <= tmo_cnt + 1'b1;
      end
`endif
    end
  end
endmodule
